// File: rtl/fwrisc_bus_arb_if.sv
// Request/response bus shared by the fetch port, the data port and the memory side.
// The requester drives the master modport; the responder drives the slave modport.
interface fwrisc_bus_arb_if;
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, write, wdata, wstb, input ready, rdata);
    modport slave  (input valid, addr, write, wdata, wstb, output ready, rdata);
endinterface

// File: rtl/fwrisc_bus_arb.sv
// Fetch/data arbiter for one single-ported memory bus, data-first with a bounded streak.
// Optional bus watchdog enabled by defining FWRISC_BUS_ARB_TIMEOUT_EN.
module fwrisc_bus_arb #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    fwrisc_bus_arb_if.slave   ireq,
    fwrisc_bus_arb_if.slave   dreq,
    fwrisc_bus_arb_if.master  bus,
    output logic              busy_o,
    output logic              berr_o
);
    typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        bvalid_q, bvalid_d;
    logic [31:0] baddr_q, baddr_d;
    logic        bwrite_q, bwrite_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [3:0]  bwstb_q, bwstb_d;
    logic        tmo_fire;
    logic        done;

    // Fetches are always full-word reads, so the fetch port's write fields are ignored.
    logic unused_fetch_fields;
    assign unused_fetch_fields = ^{ireq.write, ireq.wdata, ireq.wstb};

`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        berr_q, berr_d;

    assign tmo_fire = (state_q != IDLE) && !bus.ready && (tmo_q == 16'(TIMEOUT_CYCLES));
    assign tmo_d    = ((state_q != IDLE) && !done) ? tmo_q + 16'd1 : 16'd0;
    assign berr_d   = berr_q | tmo_fire;
    assign berr_o   = berr_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            berr_q <= berr_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = TIMEOUT_CYCLES[0];
    assign tmo_fire       = 1'b0;
    assign berr_o         = 1'b0;
`endif

    assign done = (state_q != IDLE) && (bus.ready || tmo_fire);

    assign busy_o    = (state_q != IDLE);
    assign bus.valid = bvalid_q;
    assign bus.addr  = baddr_q;
    assign bus.write = bwrite_q;
    assign bus.wdata = bwdata_q;
    assign bus.wstb  = bwstb_q;

    // A watchdog completion substitutes a recognisable poison word for the read data.
    assign ireq.ready = (state_q == IFETCH) && done;
    assign dreq.ready = (state_q == DATA) && done;
    assign ireq.rdata = tmo_fire ? 32'hDEAD_BEEF : bus.rdata;
    assign dreq.rdata = tmo_fire ? 32'hDEAD_BEEF : bus.rdata;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            streak_q <= '0;
            bvalid_q <= 1'b0;
            baddr_q  <= '0;
            bwrite_q <= 1'b0;
            bwdata_q <= '0;
            bwstb_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            bvalid_q <= bvalid_d;
            baddr_q  <= baddr_d;
            bwrite_q <= bwrite_d;
            bwdata_q <= bwdata_d;
            bwstb_q  <= bwstb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        bvalid_d = bvalid_q;
        baddr_d  = baddr_q;
        bwrite_d = bwrite_q;
        bwdata_d = bwdata_q;
        bwstb_d  = bwstb_q;
        case (state_q)
            IDLE: begin
                // Data wins contention until it has taken MAX_DATA_STREAK contested grants in a row.
                if (ireq.valid && (!dreq.valid || streak_q == STREAK_MAX)) begin
                    state_d  = IFETCH;
                    streak_d = '0;
                    bvalid_d = 1'b1;
                    baddr_d  = ireq.addr;
                    bwrite_d = 1'b0;
                    bwdata_d = '0;
                    bwstb_d  = 4'hF;
                end else if (dreq.valid) begin
                    state_d  = DATA;
                    bvalid_d = 1'b1;
                    baddr_d  = dreq.addr;
                    bwrite_d = dreq.write;
                    bwdata_d = dreq.wdata;
                    bwstb_d  = dreq.wstb;
                    if (ireq.valid) streak_d = streak_q + 4'd1;
                end
            end
            IFETCH, DATA: begin
                if (done) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fwrisc_bus_arb.sv
// Bench for fwrisc_bus_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration rules.
module tb_fwrisc_bus_arb;
    localparam int MDS = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, berr;
    always #5 clk = ~clk;

    fwrisc_bus_arb_if ireq();
    fwrisc_bus_arb_if dreq();
    fwrisc_bus_arb_if bus();

    fwrisc_bus_arb #(.MAX_DATA_STREAK(MDS), .TIMEOUT_CYCLES(TMO)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .ireq(ireq), .dreq(dreq), .bus(bus),
        .busy_o(busy), .berr_o(berr)
    );

    int errors = 0;
    int checks = 0;

    // Reference: who owns the bus, what was latched, and the contested-data streak.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic        m_write = 1'b0;
    logic [3:0]  m_wstb = '0;
    int          m_streak = 0;
    int          m_wait = 0;
    bit          m_berr = 1'b0;
    bit          prev_bvalid = 1'b0;
    bit          i_rdy_seen = 1'b0, d_rdy_seen = 1'b0;
    int          glog[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_i(input bit v, input logic [31:0] a);
        ireq.valid = v; ireq.addr = a;
        ireq.write = 1'($urandom); ireq.wdata = $urandom; ireq.wstb = 4'($urandom);
    endtask

    task automatic drive_d(input bit v, input logic [31:0] a, input bit w,
                           input logic [31:0] wd, input logic [3:0] s);
        dreq.valid = v; dreq.addr = a; dreq.write = w; dreq.wdata = wd; dreq.wstb = s;
    endtask

    task automatic model_grant(input int who);
        m_owner = who;
        if (who == 1) begin
            m_addr = ireq.addr; m_write = 1'b0; m_wdata = '0; m_wstb = 4'hF;
            m_streak = 0;
        end else begin
            m_addr = dreq.addr; m_write = dreq.write; m_wdata = dreq.wdata; m_wstb = dreq.wstb;
            if (ireq.valid) m_streak = (m_streak + 1 > MDS) ? MDS : m_streak + 1;
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return at posedge+1.
    task automatic cycle();
        bit fire, done;
        @(negedge clk);
        if (!rst_n) begin
            check_eq("rst_busy", busy, 0);
            check_eq("rst_bvalid", bus.valid, 0);
            check_eq("rst_iready", ireq.ready, 0);
            check_eq("rst_dready", dreq.ready, 0);
            check_eq("rst_berr", berr, 0);
            check_eq("rst_baddr", bus.addr, 0);
            check_eq("rst_bwstb", bus.wstb, 0);
            m_owner = 0; m_streak = 0; m_wait = 0; m_berr = 1'b0;
        end else begin
            fire = 1'b0;
`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
            fire = (m_owner != 0) && !bus.ready && (m_wait == TMO);
`endif
            done = (m_owner != 0) && (bus.ready || fire);
            check_eq("busy", busy, m_owner != 0);
            check_eq("bvalid", bus.valid, m_owner != 0);
            if (m_owner != 0) begin
                check_eq("baddr", bus.addr, m_addr);
                check_eq("bwrite", bus.write, m_write);
                check_eq("bwdata", bus.wdata, m_wdata);
                check_eq("bwstb", bus.wstb, m_wstb);
            end
            check_eq("iready", ireq.ready, (m_owner == 1) && done);
            check_eq("dready", dreq.ready, (m_owner == 2) && done);
            if (m_owner == 1 && done) check_eq("idata", ireq.rdata, fire ? 32'hDEAD_BEEF : bus.rdata);
            if (m_owner == 2 && done) check_eq("drdata", dreq.rdata, fire ? 32'hDEAD_BEEF : bus.rdata);
            check_eq("berr", berr, m_berr);
            if (bus.valid && !prev_bvalid) glog.push_back(bus.addr[31] ? 1 : 2);
            if (fire) m_berr = 1'b1;
            m_wait = ((m_owner != 0) && !done) ? m_wait + 1 : 0;
            if (done) m_owner = 0;
            else if (m_owner == 0) begin
                if (ireq.valid && dreq.valid) model_grant((m_streak == MDS) ? 1 : 2);
                else if (ireq.valid) model_grant(1);
                else if (dreq.valid) model_grant(2);
            end
        end
        prev_bvalid = bus.valid;
        i_rdy_seen = ireq.ready;
        d_rdy_seen = dreq.ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_g[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        int n;
        drive_i(0, 0); drive_d(0, 0, 0, 0, 0);
        bus.ready = 1'b0; bus.rdata = '0;
        repeat (2) cycle();
        rst_n = 1'b1;

        // Single fetch, bready two cycles after bvalid.
        drive_i(1, 32'h8000_0000); bus.rdata = 32'h0000_0013;
        cycle();
        cycle();
        cycle();
        bus.ready = 1'b1;
        cycle();
        check_eq("fetch_iready_seen", i_rdy_seen, 1);
        drive_i(0, 0); bus.ready = 1'b0;
        cycle();

        // Store with immediate bready.
        drive_d(1, 32'h100, 1, 32'hA5A5_5A5A, 4'b0011); bus.ready = 1'b1;
        cycle();
        cycle();
        check_eq("store_dready_seen", d_rdy_seen, 1);
        drive_d(0, 0, 0, 0, 0);
        cycle();
        check_eq("store_dready_once", d_rdy_seen, 0);

        // Stability: requester misbehaves during a long wait; bus fields must not move.
        bus.ready = 1'b0;
        drive_d(1, 32'h200, 0, 32'h1234_5678, 4'hF);
        cycle();
        repeat (10) begin
            drive_d(1'($urandom), $urandom & 32'h7FFF_FFFF, 1'($urandom), $urandom, 4'($urandom));
            cycle();
        end
        bus.ready = 1'b1; bus.rdata = 32'hCAFE_0001;
        cycle();
        check_eq("stab_dready_seen", d_rdy_seen, 1);
        drive_d(0, 0, 0, 0, 0); bus.ready = 1'b0;
        cycle();

        // Build up a data streak, then reset in the middle of a data transaction.
        drive_i(1, 32'h8000_0100); drive_d(1, 32'h300, 0, 0, 4'hF); bus.ready = 1'b1;
        repeat (6) cycle();
        bus.ready = 1'b0;
        cycle();
        bus.ready = 1'b1;
        #1;
        check_eq("pre_rst_dready", dreq.ready, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_bvalid", bus.valid, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_dready", dreq.ready, 0);
        cycle();
        rst_n = 1'b1;

        // Fairness with both ports always requesting and an always-ready bus.
        glog.delete();
        repeat (20) cycle();
        n = glog.size();
        check_eq("grant_count", n, 10);
        for (int i = 0; i < 10; i++)
            if (i < n) check_eq($sformatf("grant_order[%0d]", i), glog[i], exp_g[i]);
        drive_i(0, 0); drive_d(0, 0, 0, 0, 0); bus.ready = 1'b0;
        cycle();

`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
        // Fetch against a bus that never answers.
        drive_i(1, 32'h8000_0040);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!i_rdy_seen && n < 30);
        check_eq("tmo_iready_seen", i_rdy_seen, 1);
        drive_i(0, 0);
        cycle();
        check_eq("tmo_berr_set", berr, 1);
        drive_d(1, 32'h400, 0, 0, 4'hF); bus.ready = 1'b1;
        cycle();
        cycle();
        drive_d(0, 0, 0, 0, 0); bus.ready = 1'b0;
        cycle();
        check_eq("tmo_berr_sticky", berr, 1);
`endif

        // Randomized traffic; a port only holds its request while it owns the bus.
        repeat (3000) begin
            if (m_owner != 1)
                drive_i($urandom_range(0, 9) < 6, 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC));
            if (m_owner != 2)
                drive_d($urandom_range(0, 9) < 6, $urandom & 32'h7FFF_FFFF, 1'($urandom),
                        $urandom, 4'($urandom));
            bus.ready = 1'($urandom);
            bus.rdata = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
